// File: rtl/chan_pkg.sv
// Shared definitions for the channel record deassembler.
// Record field widths, the packed record layout {first,addr,frac,vl,vr}
// (43 bits), byte-index constants for the mix and address byte sequences,
// and the byte-counter advance helper.
package chan_pkg;

  localparam int ADDR_W = 22;
  localparam int FRAC_W = 8;
  localparam int VOL_W  = 6;
  localparam int REC_W  = 1 + ADDR_W + FRAC_W + 2 * VOL_W;

  localparam logic [1:0] MIX_FRAC = 2'd0;
  localparam logic [1:0] MIX_VL   = 2'd1;
  localparam logic [1:0] MIX_VR   = 2'd2;
  localparam logic [1:0] ADDR_HI  = 2'd0;
  localparam logic [1:0] ADDR_MID = 2'd1;
  localparam logic [1:0] ADDR_LO  = 2'd2;

  typedef struct packed {
    logic              first;
    logic [ADDR_W-1:0] addr;
    logic [FRAC_W-1:0] frac;
    logic [VOL_W-1:0]  vl;
    logic [VOL_W-1:0]  vr;
  } chan_rec_t;

  // Byte counters run 0,1,2,0,...
  function automatic logic [1:0] cnt_next(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/chan_rec_asm_if.sv
// Bus between the channel controller / mixer side and chan_rec_asm.
// Byte input: in_data, in_stb_addr, in_stb_mix, sync_stb.
// Record output: rec_valid/rec_ready handshake, rec_addr, rec_frac, rec_vl,
// rec_vr, rec_first; status: fifo_level, ovf, seq_err.
// slave  : the deassembler side; master : the producer/consumer side.
interface chan_rec_asm_if #(
  parameter int AW = 2
);
  import chan_pkg::*;

  logic [7:0]        in_data;
  logic              in_stb_addr;
  logic              in_stb_mix;
  logic              sync_stb;
  logic              rec_valid;
  logic              rec_ready;
  logic [ADDR_W-1:0] rec_addr;
  logic [FRAC_W-1:0] rec_frac;
  logic [VOL_W-1:0]  rec_vl;
  logic [VOL_W-1:0]  rec_vr;
  logic              rec_first;
  logic [AW:0]       fifo_level;
  logic              ovf;
  logic              seq_err;

  modport slave (
    input  in_data, in_stb_addr, in_stb_mix, sync_stb, rec_ready,
    output rec_valid, rec_addr, rec_frac, rec_vl, rec_vr, rec_first,
           fifo_level, ovf, seq_err
  );

  modport master (
    output in_data, in_stb_addr, in_stb_mix, sync_stb, rec_ready,
    input  rec_valid, rec_addr, rec_frac, rec_vl, rec_vr, rec_first,
           fifo_level, ovf, seq_err
  );

endinterface

// File: rtl/chan_rec_fifo.sv
// Generic first-word-fall-through FIFO with occupancy level.
// Ports: clk, rst (async active-high), push/din write side, pop read request
// (ignored while empty), dout head word (0 while empty), valid, full, level.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module chan_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic [AW:0]  level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign valid   = (level != '0);
  assign full    = (level == FULL_LVL);
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH == 2**AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/chan_rec_asm.sv
// Channel record deassembler.
// Collects frac,vl,vr (in_stb_mix) and addrhi,addrmid,addrlo (in_stb_addr)
// into one record; the addrlo byte completes it combinationally and pushes it
// into a FWFT record FIFO whose head drives the rec_* outputs.
// Ports: clk, rst (async active-high), bus (chan_rec_asm_if.slave).
// Optional feature: define CHAN_ASM_SEQCHK_EN to enable the byte-sequence
// checker driving seq_err; otherwise seq_err is tied 0.
module chan_rec_asm
  import chan_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  chan_rec_asm_if.slave         bus
);

  logic [1:0]        mix_cnt;
  logic [1:0]        addr_cnt;
  logic [FRAC_W-1:0] frac_q;
  logic [VOL_W-1:0]  vl_q;
  logic [VOL_W-1:0]  vr_q;
  logic [5:0]        hi_q;
  logic [7:0]        mid_q;
  logic              first_pend;
  logic              ovf_q;
  logic              complete;
  logic              full;
  logic              drop;
  chan_rec_t         rec_in;
  chan_rec_t         rec_head;

  assign complete = bus.in_stb_addr && (addr_cnt == ADDR_LO);
  // pop is rec_ready alone: a full FIFO always has a valid head.
  assign drop     = complete && full && !bus.rec_ready;

  always_comb begin
    rec_in       = '0;
    rec_in.first = first_pend;
    rec_in.addr  = {hi_q, mid_q, bus.in_data};
    rec_in.frac  = frac_q;
    rec_in.vl    = vl_q;
    rec_in.vr    = vr_q;
  end

  // Staging bytes are qualified by the counters, so they need no reset.
  always_ff @(posedge clk) begin
    if (bus.in_stb_mix) begin
      case (mix_cnt)
        MIX_FRAC: frac_q <= bus.in_data;
        MIX_VL:   vl_q   <= bus.in_data[VOL_W-1:0];
        MIX_VR:   vr_q   <= bus.in_data[VOL_W-1:0];
        default:  ;
      endcase
    end
    if (bus.in_stb_addr) begin
      case (addr_cnt)
        ADDR_HI:  hi_q  <= bus.in_data[5:0];
        ADDR_MID: mid_q <= bus.in_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_cnt    <= '0;
      addr_cnt   <= '0;
      first_pend <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (bus.in_stb_mix)  mix_cnt  <= cnt_next(mix_cnt);
      if (bus.in_stb_addr) addr_cnt <= cnt_next(addr_cnt);
      // A same-cycle sync leaves first_pend set after tagging this record.
      if (bus.sync_stb)   first_pend <= 1'b1;
      else if (complete)  first_pend <= 1'b0;
      if (drop)              ovf_q <= 1'b1;
      else if (bus.sync_stb) ovf_q <= 1'b0;
    end
  end

`ifdef CHAN_ASM_SEQCHK_EN
  logic seq_err_q;
  logic seq_bad;

  assign seq_bad = (bus.in_stb_addr && (addr_cnt == ADDR_HI) && (mix_cnt != MIX_FRAC)) ||
                   (bus.in_stb_mix && (addr_cnt != ADDR_HI)) ||
                   (bus.in_stb_addr && bus.in_stb_mix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               seq_err_q <= 1'b0;
    else if (seq_bad)      seq_err_q <= 1'b1;
    else if (bus.sync_stb) seq_err_q <= 1'b0;
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  chan_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (complete),
    .din   (rec_in),
    .pop   (bus.rec_ready),
    .dout  (rec_head),
    .valid (bus.rec_valid),
    .full  (full),
    .level (bus.fifo_level)
  );

  assign bus.rec_first = rec_head.first;
  assign bus.rec_addr  = rec_head.addr;
  assign bus.rec_frac  = rec_head.frac;
  assign bus.rec_vl    = rec_head.vl;
  assign bus.rec_vr    = rec_head.vr;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chan_rec_asm.sv
// Directed testbench for chan_rec_asm (DEPTH=4).
module tb_chan_rec_asm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  chan_rec_asm_if #(.AW(2)) bus ();

  chan_rec_asm #(.DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit is_addr, input logic [7:0] d);
    bus.in_data = d;
    if (is_addr) bus.in_stb_addr = 1'b1;
    else         bus.in_stb_mix  = 1'b1;
    tick();
    bus.in_stb_addr = 1'b0;
    bus.in_stb_mix  = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] f, input logic [7:0] l, input logic [7:0] r,
                          input logic [7:0] h, input logic [7:0] m, input logic [7:0] lo);
    send_byte(1'b0, f);
    send_byte(1'b0, l);
    send_byte(1'b0, r);
    send_byte(1'b1, h);
    send_byte(1'b1, m);
    send_byte(1'b1, lo);
  endtask

  task automatic pulse_sync();
    bus.sync_stb = 1'b1;
    tick();
    bus.sync_stb = 1'b0;
  endtask

  task automatic pop_one();
    bus.rec_ready = 1'b1;
    tick();
    bus.rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.rec_valid); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", bus.ovf); end
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %0b exp 0", bus.seq_err); end
    checks++; if ({bus.rec_addr, bus.rec_frac, bus.rec_vl, bus.rec_vr, bus.rec_first} !== 43'd0) begin
      errors++; $display("FAIL reset_fields got addr %h frac %h", bus.rec_addr, bus.rec_frac); end
  endtask

  task automatic test_basic();
    send_byte(1'b0, 8'h5A);
    send_byte(1'b0, 8'h3F);
    send_byte(1'b0, 8'h01);
    send_byte(1'b1, 8'h15);
    send_byte(1'b1, 8'h80);
    checks++; if (bus.rec_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", bus.rec_valid); end
    send_byte(1'b1, 8'h42);
    checks++; if (bus.rec_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", bus.rec_valid); end
    checks++; if (bus.rec_addr !== 22'h158042) begin errors++; $display("FAIL basic_addr got %h exp 158042", bus.rec_addr); end
    checks++; if (bus.rec_frac !== 8'h5A) begin errors++; $display("FAIL basic_frac got %h exp 5a", bus.rec_frac); end
    checks++; if (bus.rec_vl !== 6'h3F) begin errors++; $display("FAIL basic_vl got %h exp 3f", bus.rec_vl); end
    checks++; if (bus.rec_vr !== 6'h01) begin errors++; $display("FAIL basic_vr got %h exp 01", bus.rec_vr); end
    checks++; if (bus.rec_first !== 1'b0) begin errors++; $display("FAIL basic_first got %0b exp 0", bus.rec_first); end
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d exp 1", bus.fifo_level); end
    pop_one();
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL basic_drain_level got %0d exp 0", bus.fifo_level); end
    // ready on an empty FIFO must not underflow
    pop_one();
    checks++; if (bus.fifo_level !== 3'd0 || bus.rec_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pop level %0d valid %0b exp 0/0", bus.fifo_level, bus.rec_valid); end
  endtask

  task automatic test_first_tag();
    pulse_sync();
    for (int i = 0; i < 3; i++)
      send_rec(8'h20 + 8'(i), 8'(i + 1), 8'(i + 2), 8'h3F, 8'hA0, 8'(i));
    checks++; if (bus.fifo_level !== 3'd3) begin errors++; $display("FAIL first_level got %0d exp 3", bus.fifo_level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rec_addr !== (22'h3FA000 | 22'(i))) begin
        errors++; $display("FAIL first_addr%0d got %h exp %h", i, bus.rec_addr, 22'h3FA000 | 22'(i)); end
      checks++; if (bus.rec_frac !== 8'h20 + 8'(i)) begin
        errors++; $display("FAIL first_frac%0d got %h exp %h", i, bus.rec_frac, 8'h20 + 8'(i)); end
      checks++; if (bus.rec_first !== (i == 0)) begin
        errors++; $display("FAIL first_tag%0d got %0b exp %0b", i, bus.rec_first, (i == 0)); end
      pop_one();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++)
      send_rec(8'h40 + 8'(i), 8'h01, 8'h02, 8'h00, 8'h00, 8'h40 + 8'(i));
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_full_level got %0d exp 4", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0b exp 0", bus.ovf); end
    send_rec(8'h44, 8'h01, 8'h02, 8'h00, 8'h00, 8'h44);
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", bus.ovf); end
    checks++; if (bus.rec_addr !== 22'h000040) begin errors++; $display("FAIL ovf_head got %h exp 000040", bus.rec_addr); end
    pulse_sync();
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", bus.ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [21:0] exp_addr [4];
    logic        exp_first [4];
    exp_addr  = '{22'h000041, 22'h000042, 22'h000043, 22'h000050};
    exp_first = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_byte(1'b0, 8'h50);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00);
    bus.in_data     = 8'h50;
    bus.in_stb_addr = 1'b1;
    bus.rec_ready   = 1'b1;
    tick();
    bus.in_stb_addr = 1'b0;
    bus.rec_ready   = 1'b0;
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level got %0d exp 4", bus.fifo_level); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL pp_ovf got %0b exp 0", bus.ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rec_addr !== exp_addr[i]) begin
        errors++; $display("FAIL pp_addr%0d got %h exp %h", i, bus.rec_addr, exp_addr[i]); end
      checks++; if (bus.rec_first !== exp_first[i]) begin
        errors++; $display("FAIL pp_first%0d got %0b exp %0b", i, bus.rec_first, exp_first[i]); end
      pop_one();
    end
    checks++; if (bus.rec_valid !== 1'b0 || bus.fifo_level !== 3'd0) begin
      errors++; $display("FAIL pp_empty valid %0b level %0d exp 0/0", bus.rec_valid, bus.fifo_level); end
  endtask

  task automatic test_reset_mid_record();
    send_rec(8'h60, 8'h01, 8'h02, 8'h00, 8'h00, 8'h60);
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    do_reset();
    checks++; if (bus.fifo_level !== 3'd0 || bus.rec_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_flush level %0d valid %0b exp 0/0", bus.fifo_level, bus.rec_valid); end
    send_rec(8'h11, 8'hE2, 8'h33, 8'hC1, 8'h02, 8'h03);
    checks++; if (bus.rec_frac !== 8'h11) begin errors++; $display("FAIL rmid_frac got %h exp 11", bus.rec_frac); end
    checks++; if (bus.rec_vl !== 6'h22) begin errors++; $display("FAIL rmid_vl got %h exp 22", bus.rec_vl); end
    checks++; if (bus.rec_vr !== 6'h33) begin errors++; $display("FAIL rmid_vr got %h exp 33", bus.rec_vr); end
    checks++; if (bus.rec_addr !== 22'h010203) begin errors++; $display("FAIL rmid_addr got %h exp 010203", bus.rec_addr); end
    checks++; if (bus.rec_first !== 1'b0) begin errors++; $display("FAIL rmid_first got %0b exp 0", bus.rec_first); end
    pop_one();
  endtask

  task automatic test_seq_check();
    logic exp_err;
`ifdef CHAN_ASM_SEQCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send_byte(1'b0, 8'h77);
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL seq_pre got %0b exp 0", bus.seq_err); end
    send_byte(1'b1, 8'h01);
    checks++; if (bus.seq_err !== exp_err) begin errors++; $display("FAIL seq_err got %0b exp %0b", bus.seq_err, exp_err); end
    pulse_sync();
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear got %0b exp 0", bus.seq_err); end
  endtask

  initial begin
    bus.in_data     = 8'h00;
    bus.in_stb_addr = 1'b0;
    bus.in_stb_mix  = 1'b0;
    bus.sync_stb    = 1'b0;
    bus.rec_ready   = 1'b0;
    test_reset();
    test_basic();
    test_first_tag();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_record();
    test_seq_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
